// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- multi-channel interrupt controller
//
// Takes NUM_CH interrupt lines and gives the control unit one request at a
// time, together with the address of the vector slot to jump to. Requests are
// rising-edge detected and latched as pending. A software mask selects which
// pending channels may be requested, and channel 0 has the highest priority.
// Once the control unit acknowledges a request, no new request is raised
// until the handler's RTI retires.
//
// Build option:
//   INT_LEVEL_EN  defined   -> level-sensitive mode. pending follows irq_in
//                              every cycle, and ack does not clear it.
//                 undefined -> edge-latched mode (default).
//
// Ports:
//   clk         in   1        system clock, rising edge
//   rst         in   1        synchronous, active-high reset
//   irq_in      in   NUM_CH   raw request lines (already synchronous to clk)
//   mask_we     in   1        load mask_wdata into the mask this cycle
//   mask_wdata  in   NUM_CH   new mask value, 1 = channel enabled
//   int_ack     in   1        control unit has injected the interrupt
//   rti         in   1        RTI instruction retired
//   int_req     out  1        interrupt request to the control unit
//   int_vec     out  ADDR_W   vector slot address, VEC_BASE + int_ch
//   int_ch      out  CH_W     channel being requested or serviced
//   pending     out  NUM_CH   pending register (shown regardless of mask)
//   mask_out    out  NUM_CH   current mask
//   busy        out  1        handler in progress (SERVICE state)
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter  int NUM_CH   = 4,
    parameter  int ADDR_W   = 8,
    parameter  int VEC_BASE = 1,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_wdata,
    input  logic              int_ack,
    input  logic              rti,
    output logic              int_req,
    output logic [ADDR_W-1:0] int_vec,
    output logic [CH_W-1:0]   int_ch,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] mask_out,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // The vector address is computed at least 32 bits wide and then truncated
    // to ADDR_W, so VEC_BASE + NUM_CH - 1 wraps the way the PC would.
    localparam int SUM_W = (ADDR_W > 32) ? ADDR_W : 32;

    logic [1:0]        state;
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] pending_nxt;
    logic [NUM_CH-1:0] mask_r;
    logic [NUM_CH-1:0] eligible;
    logic [CH_W-1:0]   int_ch_r;
    logic [ADDR_W-1:0] int_vec_r;
    logic              int_req_r;
    logic              busy_r;
    logic [CH_W-1:0]   win_ch;
    logic              win_any;

    function automatic logic [ADDR_W-1:0] vec_of(input logic [CH_W-1:0] ch);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(VEC_BASE) + SUM_W'(ch);
        return sum[ADDR_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Pending register update
    // -------------------------------------------------------------------------
`ifdef INT_LEVEL_EN
    // Level mode: pending is the sampled line. A handler must drop its source
    // before RTI, otherwise the channel is requested again.
    always_comb begin
        pending_nxt = irq_in;
    end
`else
    logic [NUM_CH-1:0] irq_prev;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr;

    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default value
        // first. A path that leaves a signal unassigned infers a latch.
        clr = '0;
        if (state == ST_REQ && int_ack) begin
            for (int i = 0; i < NUM_CH; i++) begin
                clr[i] = (int_ch_r == CH_W'(i));
            end
        end
        rise        = irq_in & ~irq_prev;
        // The set is applied after the clear. A new edge that arrives in the
        // same cycle as its ack is still kept.
        pending_nxt = (pending_r & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) irq_prev <= '0;
        else     irq_prev <= irq_in;
    end
`endif

    // -------------------------------------------------------------------------
    // Fixed-priority arbitration over the eligible set (lowest index wins).
    // This uses the registered mask, so a mask write takes effect one cycle
    // after it is made.
    // -------------------------------------------------------------------------
    assign eligible = pending_r & mask_r;

    always_comb begin
        win_ch  = '0;
        win_any = |eligible;
        // Scan downward so that the last hit, which is the lowest index, wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) win_ch = CH_W'(i);
        end
    end

    // -------------------------------------------------------------------------
    // Pending and mask registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together from values sampled before the edge, so the
        // order of the statements does not matter.
        if (rst) begin
            pending_r <= '0;
            mask_r    <= '1;
        end else begin
            pending_r <= pending_nxt;
            if (mask_we) mask_r <= mask_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Request / service FSM. int_ch and int_vec are latched only on the
    // IDLE -> REQ transition. A later mask write or a higher-priority edge
    // therefore cannot change or withdraw a request that is already raised.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            int_req_r <= 1'b0;
            busy_r    <= 1'b0;
            int_ch_r  <= '0;
            int_vec_r <= vec_of('0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        state     <= ST_REQ;
                        int_req_r <= 1'b1;
                        int_ch_r  <= win_ch;
                        int_vec_r <= vec_of(win_ch);
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state     <= ST_SERVICE;
                        int_req_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (rti) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    int_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign int_req  = int_req_r;
    assign int_vec  = int_vec_r;
    assign int_ch   = int_ch_r;
    assign pending  = pending_r;
    assign mask_out = mask_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- scoreboard bench for int_ctrl (NUM_CH=4, ADDR_W=8, VEC_BASE=1)
//
// The driver applies directed vectors. At each checkpoint it pushes a
// hand-computed snapshot of the expected outputs into exp_q, tagged with the
// cycle it applies to. Whenever it expects a new request, it also pushes the
// expected channel into req_q. A separate monitor samples on the falling edge:
// it compares every snapshot that falls due, and it pops req_q each time it
// sees int_req rise.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       int_ack;
    logic       rti;
    logic       int_req;
    logic [7:0] int_vec;
    logic [1:0] int_ch;
    logic [3:0] pending;
    logic [3:0] mask_out;
    logic       busy;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_CH(4), .ADDR_W(8), .VEC_BASE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .rti        (rti),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_ch     (int_ch),
        .pending    (pending),
        .mask_out   (mask_out),
        .busy       (busy)
    );

    typedef struct {
        int         at;
        logic       req;
        logic [1:0] ch;
        logic [7:0] vec;
        logic [3:0] pend;
        logic [3:0] mask;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   req_q[$];
    int   cyc      = 0;
    int   nvec     = 0;
    int   nerr     = 0;
    logic req_prev = 1'b0;
    exp_t e_mon;
    int   ch_mon;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare the snapshots that are due, and check each new request.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e_mon = exp_q.pop_front();
            check("snap_cycle", e_mon.at, cyc);
            check("snap{req,ch,vec,pend,mask,busy}",
                  int'({int_req, int_ch, int_vec, pending, mask_out, busy}),
                  int'({e_mon.req, e_mon.ch, e_mon.vec, e_mon.pend, e_mon.mask, e_mon.busy}));
        end
        if (int_req === 1'b1 && req_prev === 1'b0) begin
            if (req_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_req @cyc %0d: got int_ch=%0d, expected no request", cyc, int_ch);
            end else begin
                ch_mon = req_q.pop_front();
                check("req{ch,vec}", int'({int_ch, int_vec}), (ch_mon << 8) | (1 + ch_mon));
            end
        end
        req_prev = int_req;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected state right after the most recent rising edge. vec = 1 + ch.
    task automatic exp_now(input logic req, input int ch, input logic [3:0] pend,
                           input logic [3:0] mask, input logic bsy);
        exp_t e;
        e.at   = cyc;
        e.req  = req;
        e.ch   = 2'(ch);
        e.vec  = 8'(1 + ch);
        e.pend = pend;
        e.mask = mask;
        e.busy = bsy;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; rti = 1'b0;
        tick(2);
        exp_now(0, 0, 4'b0000, 4'b1111, 0);
        rst = 1'b0;

`ifdef INT_LEVEL_EN
        // Level mode: a line held through ack stays pending and is requested again.
        irq_in = 4'b0010;
        tick(1); exp_now(0, 0, 4'b0010, 4'hF, 0);
        req_q.push_back(1);
        tick(1); exp_now(1, 1, 4'b0010, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 1, 4'b0010, 4'hF, 1);
        int_ack = 1'b0; rti = 1'b1;
        tick(1); exp_now(0, 1, 4'b0010, 4'hF, 0);
        rti = 1'b0;
        req_q.push_back(1);
        tick(1); exp_now(1, 1, 4'b0010, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 1, 4'b0010, 4'hF, 1);
        // The line drops before RTI, so no new request follows.
        int_ack = 1'b0; irq_in = 4'b0000;
        tick(1); exp_now(0, 1, 4'b0000, 4'hF, 1);
        rti = 1'b1;
        tick(1); exp_now(0, 1, 4'b0000, 4'hF, 0);
        rti = 1'b0;
        tick(2); exp_now(0, 1, 4'b0000, 4'hF, 0);
`else
        // Single edge on channel 2, with the line held high throughout.
        irq_in = 4'b0100;
        tick(1); exp_now(0, 0, 4'b0100, 4'hF, 0);
        req_q.push_back(2);
        tick(1); exp_now(1, 2, 4'b0100, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 2, 4'b0000, 4'hF, 1);
        int_ack = 1'b0;
        tick(3); exp_now(0, 2, 4'b0000, 4'hF, 1);
        rti = 1'b1;
        tick(1); exp_now(0, 2, 4'b0000, 4'hF, 0);
        rti = 1'b0;
        tick(1); exp_now(0, 2, 4'b0000, 4'hF, 0);
        irq_in = 4'b0000;
        tick(1);

        // Priority: channels 1 and 3 rise together.
        irq_in = 4'b1010;
        tick(1); exp_now(0, 2, 4'b1010, 4'hF, 0);
        req_q.push_back(1);
        tick(1); exp_now(1, 1, 4'b1010, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 1, 4'b1000, 4'hF, 1);
        int_ack = 1'b0; rti = 1'b1;
        tick(1); exp_now(0, 1, 4'b1000, 4'hF, 0);
        rti = 1'b0;
        req_q.push_back(3);
        tick(1); exp_now(1, 3, 4'b1000, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 3, 4'b0000, 4'hF, 1);
        int_ack = 1'b0; rti = 1'b1;
        tick(1); exp_now(0, 3, 4'b0000, 4'hF, 0);
        rti = 1'b0;
        tick(2); exp_now(0, 3, 4'b0000, 4'hF, 0);
        irq_in = 4'b0000;
        tick(1);

        // Masking: a masked channel becomes pending but is not requested.
        mask_we = 1'b1; mask_wdata = 4'b1110;
        tick(1); exp_now(0, 3, 4'b0000, 4'hE, 0);
        mask_we = 1'b0; irq_in = 4'b0001;
        tick(1); exp_now(0, 3, 4'b0001, 4'hE, 0);
        tick(2); exp_now(0, 3, 4'b0001, 4'hE, 0);
        mask_we = 1'b1; mask_wdata = 4'b1111;
        tick(1); exp_now(0, 3, 4'b0001, 4'hF, 0);
        mask_we = 1'b0;
        req_q.push_back(0);
        tick(1); exp_now(1, 0, 4'b0001, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 0, 4'b0000, 4'hF, 1);
        int_ack = 1'b0; rti = 1'b1; irq_in = 4'b0000;
        tick(1); exp_now(0, 0, 4'b0000, 4'hF, 0);
        rti = 1'b0;

        // Set-wins and preemption while REQ is held for channel 2.
        irq_in = 4'b0100;
        tick(1); exp_now(0, 0, 4'b0100, 4'hF, 0);
        req_q.push_back(2);
        tick(1); exp_now(1, 2, 4'b0100, 4'hF, 0);
        irq_in = 4'b0101; mask_we = 1'b1; mask_wdata = 4'b0000;
        tick(1); exp_now(1, 2, 4'b0101, 4'h0, 0);
        mask_we = 1'b0; irq_in = 4'b0001;
        tick(1); exp_now(1, 2, 4'b0101, 4'h0, 0);
        int_ack = 1'b1; irq_in = 4'b0101;
        tick(1); exp_now(0, 2, 4'b0101, 4'h0, 1);
        int_ack = 1'b0; mask_we = 1'b1; mask_wdata = 4'b1111;
        tick(1); exp_now(0, 2, 4'b0101, 4'hF, 1);
        mask_we = 1'b0; rti = 1'b1;
        tick(1); exp_now(0, 2, 4'b0101, 4'hF, 0);
        rti = 1'b0;
        req_q.push_back(0);
        tick(1); exp_now(1, 0, 4'b0101, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 0, 4'b0100, 4'hF, 1);
        int_ack = 1'b0; rti = 1'b1;
        tick(1); exp_now(0, 0, 4'b0100, 4'hF, 0);
        rti = 1'b0;
        req_q.push_back(2);
        tick(1); exp_now(1, 2, 4'b0100, 4'hF, 0);
        int_ack = 1'b1;
        tick(1); exp_now(0, 2, 4'b0000, 4'hF, 1);
        int_ack = 1'b0; rti = 1'b1;
        tick(1); exp_now(0, 2, 4'b0000, 4'hF, 0);
        rti = 1'b0; irq_in = 4'b0000;
        tick(1);

        // Ack and rti in IDLE are ignored, and rti in REQ is ignored.
        irq_in = 4'b0010;
        tick(1); exp_now(0, 2, 4'b0010, 4'hF, 0);
        int_ack = 1'b1; rti = 1'b1;
        req_q.push_back(1);
        tick(1); exp_now(1, 1, 4'b0010, 4'hF, 0);
        int_ack = 1'b0;
        tick(1); exp_now(1, 1, 4'b0010, 4'hF, 0);
        rti = 1'b0; int_ack = 1'b1;
        tick(1); exp_now(0, 1, 4'b0000, 4'hF, 1);
        int_ack = 1'b0;

        // Reset mid-service, with channel 1 pending again.
        irq_in = 4'b0000;
        tick(1); exp_now(0, 1, 4'b0000, 4'hF, 1);
        irq_in = 4'b0010; mask_we = 1'b1; mask_wdata = 4'b0011;
        tick(1); exp_now(0, 1, 4'b0010, 4'h3, 1);
        mask_we = 1'b0; rst = 1'b1; irq_in = 4'b0000;
        tick(1); exp_now(0, 0, 4'b0000, 4'hF, 0);
        rst = 1'b0; rti = 1'b1;
        tick(1); exp_now(0, 0, 4'b0000, 4'hF, 0);
        rti = 1'b0;
        tick(2); exp_now(0, 0, 4'b0000, 4'hF, 0);
`endif

        @(negedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised multi-channel interrupt controller. It replaces the single raw interrupt line into the control unit.
- Detects rising edges on NUM_CH request lines, latches them as pending and applies a software-writable mask.
- Arbitrates by fixed priority, with channel 0 highest.
- Presents one request plus a vector address to the control unit. It blocks further requests until the handler signals return (RTI).

Parameters:
- NUM_CH, default 4: number of interrupt channels; legal range 1..16.
- ADDR_W, default 8: width of the vector address, matching the PC width.
- VEC_BASE, default 1: memory address of channel 0's vector slot. Channel i's slot is VEC_BASE+i.
- CH_W, default $clog2(NUM_CH) with a minimum of 1: channel index width. This is a localparam.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_CH  raw request lines from peripherals; assumed already synchronous to clk.
- mask_we  in  1  on a cycle where this is 1, mask_wdata is loaded into the mask.
- mask_wdata  in  NUM_CH  new mask value; 1 means the channel is enabled.
- int_ack  in  1  one-cycle pulse from the control unit when it injects the interrupt into the pipeline.
- rti  in  1  one-cycle pulse when the RTI instruction retires.
- int_req  out  1  interrupt request to the control unit.
- int_vec  out  ADDR_W  vector slot address, VEC_BASE+int_ch, truncated to ADDR_W.
- int_ch  out  CH_W  index of the channel being requested or serviced.
- pending  out  NUM_CH  pending register, visible regardless of mask.
- mask_out  out  NUM_CH  current mask.
- busy  out  1  high while in the SERVICE state.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, irq_prev=0, mask=all ones, state=IDLE.
  - Outputs: int_req=0, int_ch=0, int_vec=VEC_BASE, busy=0.
  - Reset mid-request or mid-service abandons the operation; the next cycle is IDLE with nothing pending.
- Edge detect:
  - irq_prev<=irq_in every cycle.
  - rise[i]=irq_in[i]&~irq_prev[i]. A rise sets pending[i] even when channel i is masked.
  - A line held high produces exactly one pending set.
- Mask:
  - mask<=mask_wdata when mask_we=1.
  - The eligible set is pending & mask, using the registered mask. A mask write takes effect from the following cycle.
- FSM state IDLE:
  - If eligible is nonzero, latch int_ch to the lowest set index and go to REQ.
  - int_req=0 while in IDLE.
- FSM state REQ:
  - int_req=1; int_ch and int_vec are held stable.
  - A mask write or a higher-priority rise while in REQ does not change int_ch and does not retract the request.
  - On int_ack=1: clear pending[int_ch] and go to SERVICE. int_req is 0 from the next cycle.
- FSM state SERVICE:
  - busy=1, int_req=0, int_ch holds the serviced channel.
  - On rti=1, go to IDLE. A new arbitration can then be latched in the following cycle.
- Ignored inputs: rti in IDLE or REQ is ignored. int_ack outside REQ is ignored.
- Simultaneous events:
  - A rise on channel i in the same cycle as an ack clearing pending[i]: set wins, so pending[i]=1 afterwards.
  - Rises on several channels at once set all of them. They are served one per IDLE→REQ→SERVICE→IDLE round, in priority order.
- Latency:
  - irq_in[i] first sampled high at edge E0 (previous sample low) gives pending[i]=1 after E0 and int_req=1 after E1.
  - From rti at edge En, the next int_req is at the earliest after En+1.
- All outputs are registered.

Optional Feature:
- Macro: INT_LEVEL_EN.
- Defined: level-sensitive mode.
  - pending<=irq_in every cycle; no edge detection and no latching.
  - int_ack does not clear pending. The source must drop its line before the handler issues rti.
  - Any line still high after rti re-requests.
- Undefined: the edge-latched behaviour described above.

Test Plan:
- Reset check: rst=1 for 2 cycles → pending=0, mask_out=4'b1111, int_req=0, int_vec=8'h01, busy=0.
- Single edge:
  - Stimulus: irq_in=4'b0100 held high.
  - Expected: pending=4'b0100 after E0; int_req=1, int_ch=2, int_vec=8'h03 after E1.
  - Ack in cycle 4: pending=0, busy=1, and no re-request while the line stays high.
- Priority: irq_in 4'b1010 rising together.
  - First request: int_ch=1.
  - After ack then rti: int_ch=3 requested 2 cycles later.
  - After ack then rti: IDLE with no further request.
- Masking: mask_wdata=4'b1110 with mask_we, then a rise on channel 0.
  - Expected: pending=4'b0001 and int_req stays 0.
  - Then write mask 4'b1111: int_req=1 and int_ch=0 one cycle after the mask update.
- Set-wins and preemption:
  - In REQ for channel 2, a rise on channel 0 → int_ch stays 2.
  - Ack plus a new channel-2 rise in the same cycle → pending=4'b0101.
  - After rti, channel 0 is served first.
- Reset mid-service: while in SERVICE with pending=4'b0010, assert rst → next cycle IDLE, pending=0, busy=0; rti afterwards has no effect.
- INT_LEVEL_EN build:
  - Hold irq_in[1]=1 through ack → pending[1] stays 1.
  - After rti, int_req is reasserted with int_ch=1.
  - Drop the line before rti → no re-request.
